// File: rtl/cipher_round_sequencer_if.sv
// rtl/cipher_round_sequencer_if.sv - handshake and round-control bundle for the cipher round sequencer
// Purpose: groups the upstream block handshake, round-datapath controls,
// downstream result handshake and status into one bundle.
// Ports (signals):
//   in_valid/in_ready/decrypt - upstream block handshake and direction
//   abort                     - synchronous abandon of the current block
//   load_en/round_en          - datapath load and round-step strobes
//   round_idx/key_idx         - round number and direction-adjusted subkey index
//   last_round                - final round strobe
//   out_valid/out_ready       - downstream result handshake
//   busy/blocks_done          - status
// Modports: master drives the requests (upstream/downstream side),
//           slave is the sequencer.
interface cipher_round_sequencer_if #(
  parameter int CNT_W  = 5,
  parameter int STAT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              decrypt;
  logic              abort;
  logic              load_en;
  logic              round_en;
  logic [CNT_W-1:0]  round_idx;
  logic [CNT_W-1:0]  key_idx;
  logic              last_round;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [STAT_W-1:0] blocks_done;

  modport master (
    output in_valid, decrypt, abort, out_ready,
    input  in_ready, load_en, round_en, round_idx, key_idx, last_round,
           out_valid, busy, blocks_done
  );

  modport slave (
    input  in_valid, decrypt, abort, out_ready,
    output in_ready, load_en, round_en, round_idx, key_idx, last_round,
           out_valid, busy, blocks_done
  );
endinterface

// File: rtl/cipher_round_sequencer.sv
// rtl/cipher_round_sequencer.sv - block-cipher round sequencer with load/round/done handshakes
// Purpose: accepts a block, pulses load_en, steps the round datapath for
// NUM_ROUNDS cycles, then holds out_valid until the result is taken.
// Ports:
//   clk    - clock
//   n_rst  - asynchronous active-low reset
//   bus    - cipher_round_sequencer_if.slave (handshakes, round controls, status)
// Optional feature macro: CIPHER_SEQ_PIPE_ACCEPT_EN
//   defined   - a new block can be accepted in DONE on the output handshake
//               cycle, going straight to LOAD with no IDLE cycle.
//   undefined - blocks are accepted only in IDLE.
module cipher_round_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int CNT_W      = 5,
  parameter int STAT_W     = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  cipher_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [STAT_W-1:0] done_q, done_d;

  // Outputs are registered from the next-state values, so they line up
  // with the state they describe while staying glitch-free.
  logic              in_ready_q;
  logic              load_en_q;
  logic              round_en_q;
  logic [CNT_W-1:0]  round_idx_q;
  logic [CNT_W-1:0]  key_idx_q;
  logic              last_round_q;
  logic              out_valid_q;
  logic              busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = done_q;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dir_d   = bus.decrypt;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          cnt_d   = '0;
          state_d = ROUND;
        end
        ROUND: begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            done_d  = done_q + STAT_W'(1);
            state_d = IDLE;
`ifdef CIPHER_SEQ_PIPE_ACCEPT_EN
            if (bus.in_valid) begin
              dir_d   = bus.decrypt;
              cnt_d   = '0;
              state_d = LOAD;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      done_q       <= '0;
      in_ready_q   <= 1'b1;
      load_en_q    <= 1'b0;
      round_en_q   <= 1'b0;
      round_idx_q  <= '0;
      key_idx_q    <= '0;
      last_round_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      in_ready_q   <= (state_d == IDLE);
      load_en_q    <= (state_d == LOAD);
      round_en_q   <= (state_d == ROUND);
      round_idx_q  <= (state_d == ROUND) ? cnt_d : '0;
      // Decrypt walks the key schedule backwards.
      key_idx_q    <= (state_d != ROUND) ? '0 :
                      (dir_d ? (LAST_IDX - cnt_d) : cnt_d);
      last_round_q <= (state_d == ROUND) && (cnt_d == LAST_IDX);
      out_valid_q  <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
    end
  end

`ifdef CIPHER_SEQ_PIPE_ACCEPT_EN
  // In DONE the sequencer can take a new block exactly when the result leaves.
  assign bus.in_ready = in_ready_q |
                        ((state_q == DONE) && bus.out_ready && !bus.abort);
`else
  assign bus.in_ready = in_ready_q;
`endif

  assign bus.load_en     = load_en_q;
  assign bus.round_en    = round_en_q;
  assign bus.round_idx   = round_idx_q;
  assign bus.key_idx     = key_idx_q;
  assign bus.last_round  = last_round_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.blocks_done = done_q;

endmodule

// File: doc/cipher_round_sequencer.md
Name: cipher_round_sequencer

Overview:
- Top-level sequencer for the block-cipher round datapath.
- Accepts one data block per valid/ready handshake, pulses the data/key load, then steps the round datapath once per cycle for NUM_ROUNDS rounds.
- Presents the result with an output valid/ready handshake.
- Supplies the round index and the direction-adjusted key-schedule index. It owns its round counter; no external counter is used.

Parameters:
- NUM_ROUNDS, 16: rounds per block; legal range 2..(2**CNT_W)-1.
- CNT_W, 5: width of the round index outputs.
- STAT_W, 16: width of the completed-block status counter.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream block and key are present.
- in_ready  out  1  sequencer can accept a block.
- decrypt  in  1  direction, sampled on the accept cycle; 1 = decrypt.
- abort  in  1  synchronous abandon of the current block.
- load_en  out  1  datapath loads the block and key registers this cycle.
- round_en  out  1  datapath executes one round this cycle.
- round_idx  out  CNT_W  current round number, 0..NUM_ROUNDS-1.
- key_idx  out  CNT_W  subkey index: round_idx for encrypt, NUM_ROUNDS-1-round_idx for decrypt.
- last_round  out  1  round_en is active and round_idx == NUM_ROUNDS-1.
- out_valid  out  1  result is held in the datapath output.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  state != IDLE.
- blocks_done  out  STAT_W  count of completed output handshakes; wraps to 0.

Behaviour:
- Clock and reset: clk, reset n_rst asynchronous active-low.
- Reset values:
  - state=IDLE, round counter=0, latched direction=0, blocks_done=0.
  - Outputs after reset: in_ready=1, all other outputs 0.
- Output timing: Moore decode of state, round counter and latched direction. The only exception is in_ready under PIPE_ACCEPT_EN.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch decrypt and go to LOAD.
- LOAD:
  - Exactly one cycle.
  - load_en=1, round counter=0.
  - Go to ROUND.
- ROUND:
  - round_en=1. Counter increments by 1 each cycle.
  - When counter == NUM_ROUNDS-1: last_round=1, counter clears to 0, go to DONE.
  - Counter never reaches NUM_ROUNDS.
- DONE:
  - out_valid=1, held stable until out_ready.
  - On out_valid && out_ready: blocks_done += 1 (modulo 2**STAT_W), go to IDLE.
- Latency: accept at cycle T gives load_en at T+1, round_en T+2..T+NUM_ROUNDS+1, out_valid from T+NUM_ROUNDS+2.
- round_idx and key_idx read 0 outside ROUND.
- The decrypt input is ignored except on the accept cycle. A change mid-block has no effect.
- abort:
  - Highest priority in every state.
  - Next cycle: state=IDLE, counter=0, out_valid=0, round_en=0.
  - blocks_done is not incremented.
  - abort in IDLE with in_valid=1 does not accept the block.
- Simultaneous out_ready and abort in DONE: the abort wins and no completion is counted.
- Reset mid-operation returns to the reset values immediately, independent of clk.

Optional Feature:
- Macro: CIPHER_SEQ_PIPE_ACCEPT_EN.
- Defined:
  - In DONE, in_ready = out_ready && !abort.
  - A simultaneous output handshake and input accept goes directly to LOAD with the new direction latched, giving back-to-back blocks with no IDLE cycle.
  - blocks_done still increments on that cycle.
- Undefined:
  - in_ready=1 only in IDLE, so there is one mandatory IDLE cycle between blocks.
  - in_ready is purely registered-state decoded.

Test Plan:
- Reset, then encrypt accept at cycle 0 (NUM_ROUNDS=16) -> load_en at cycle 1; round_en cycles 2–17 with round_idx=key_idx=0..15; last_round at cycle 17 only; out_valid at cycle 18; out_ready at cycle 18 -> blocks_done=1, in_ready=1 at cycle 19.
- Decrypt block -> key_idx sequence 15,14,…,0 while round_idx runs 0..15. Toggle decrypt mid-block -> no change to the key_idx sequence.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready stays 0, blocks_done unchanged; then out_ready=1 -> counter +1.
- abort at round_idx=7 -> next cycle IDLE, round_en=0, idx=0; a new block then runs the full 16 rounds from index 0; blocks_done counts only completed blocks.
- Preload via 2**STAT_W-1 completions (or force) -> next handshake wraps blocks_done to 0. Assert n_rst at round 3 -> all outputs at reset values immediately.
- CIPHER_SEQ_PIPE_ACCEPT_EN defined, in_valid and out_ready both high in DONE -> load_en on the very next cycle, two blocks complete in 2×(NUM_ROUNDS+2) cycles. Undefined -> one extra IDLE cycle between the blocks.
